// File: rtl/remote_pkg.sv
// -----------------------------------------------------------------------------
// remote_pkg
// Shared definitions for the remote-control link (transmitter and receiver):
//   - state_e      : frame-sequencer state encoding
//   - CUSTOM_LEN   : custom-code field length in bits
//   - KEY_LEN      : key / inverted-key field length in bits
//   - INVALID_KEY  : code the receiver reports for an undecodable frame
//   - key_exists() : legality test for an 8-bit key code
// -----------------------------------------------------------------------------
package remote_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD_LO,
    ST_LEAD_HI,
    ST_CUSTOM,
    ST_KEY,
    ST_KEY_INV,
    ST_GAP
  } state_e;

  localparam int         CUSTOM_LEN  = 16;
  localparam int         KEY_LEN     = 8;
  localparam logic [7:0] INVALID_KEY = 8'hFF;

  // Legal keys live in 0..31; within that range A..E = key[4:0] (A is the MSB)
  // and the key is legal when any of the listed product terms holds.
  function automatic logic key_exists(input logic [7:0] key);
    logic a, b, c, d, e;
    {a, b, c, d, e} = key[4:0];
    return (key[7:5] == 3'b000) &&
           ((!a && !b) || (!b && !c) || (!b && !e) || (a && d) ||
            (!a && !c && !d) || (!a && !d && !e) || (!c && !d && !e) ||
            (c && d && e));
  endfunction

endpackage

// File: rtl/remote_transmitter.sv
// -----------------------------------------------------------------------------
// remote_transmitter
// Serialises a legal 8-bit key as: LEAD_LOW zeros, one high lead bit, the
// 16-bit custom code, the key, the inverted key (all MSB first), then GAP
// idle-high cycles. Illegal keys are refused with a one-cycle reject pulse.
//
// Parameters:
//   CUSTOM_CODE  custom-code field value
//   LEAD_LOW     preamble low length in cycles (1..15)
//   GAP          idle-high cycles after each frame (>= 5)
// Ports:
//   clk        in   clock, all logic on posedge
//   reset      in   asynchronous, active-low reset
//   key_valid  in   key_in is offered
//   key_in     in   [7:0] key code to send
//   key_ready  out  block can accept a key (IDLE only)
//   serial     out  line output, idle high
//   busy       out  frame or gap in progress
//   reject     out  one-cycle pulse after an illegal key is offered
// -----------------------------------------------------------------------------
module remote_transmitter
  import remote_pkg::*;
#(
  parameter logic [15:0] CUSTOM_CODE = 16'hA55A,
  parameter int          LEAD_LOW    = 4,
  parameter int          GAP         = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [7:0] key_in,
  output logic       key_ready,
  output logic       serial,
  output logic       busy,
  output logic       reject
);

  // Counter reload values: each state runs for (load + 1) cycles and leaves
  // when the counter reaches zero, so the counter never wraps.
  localparam logic [4:0] LEAD_LD   = 5'(LEAD_LOW - 1);
  localparam logic [4:0] CUSTOM_LD = 5'(CUSTOM_LEN - 1);
  localparam logic [4:0] KEY_LD    = 5'(KEY_LEN - 1);
  localparam logic [4:0] GAP_LD    = 5'(GAP - 1);

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] shreg_q, shreg_d;
  logic [7:0]  key_q, key_d;
  logic        serial_q, serial_d;
  logic        busy_q, busy_d;
  logic        key_ready_q, key_ready_d;
  logic        reject_q, reject_d;
  logic        last;

  assign last = (cnt_q == 5'd0);

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    state_d  = state_q;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    key_d    = key_q;
    reject_d = 1'b0;
    serial_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (key_valid && key_ready_q) begin
          if (key_exists(key_in)) begin
            key_d   = key_in;
            state_d = ST_LEAD_LO;
            cnt_d   = LEAD_LD;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      ST_LEAD_LO: begin
        if (last) begin
          state_d = ST_LEAD_HI;
          cnt_d   = 5'd0;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      // The lead-high bit is exactly one cycle; the receiver aligns on it.
      ST_LEAD_HI: begin
        state_d = ST_CUSTOM;
        cnt_d   = CUSTOM_LD;
        shreg_d = CUSTOM_CODE;
      end
      ST_CUSTOM: begin
        if (last) begin
          state_d = ST_KEY;
          cnt_d   = KEY_LD;
          shreg_d = {key_q, 8'h00};
        end else begin
          cnt_d   = cnt_q - 5'd1;
          shreg_d = {shreg_q[14:0], 1'b0};
        end
      end
      ST_KEY: begin
        if (last) begin
          state_d = ST_KEY_INV;
          cnt_d   = KEY_LD;
          shreg_d = {~key_q, 8'h00};
        end else begin
          cnt_d   = cnt_q - 5'd1;
          shreg_d = {shreg_q[14:0], 1'b0};
        end
      end
      ST_KEY_INV: begin
        if (last) begin
          state_d = ST_GAP;
          cnt_d   = GAP_LD;
        end else begin
          cnt_d   = cnt_q - 5'd1;
          shreg_d = {shreg_q[14:0], 1'b0};
        end
      end
      ST_GAP: begin
        if (last) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered, so they are derived from the state being
    // entered; the line then changes exactly on the transition edge.
    case (state_d)
      ST_LEAD_LO:                     serial_d = 1'b0;
      ST_CUSTOM, ST_KEY, ST_KEY_INV:  serial_d = shreg_d[15];
      default:                        serial_d = 1'b1;
    endcase
  end

  assign busy_d      = (state_d != ST_IDLE);
  assign key_ready_d = (state_d == ST_IDLE);

  // NOTE: state flops use non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 5'd0;
      shreg_q     <= 16'h0000;
      key_q       <= 8'h00;
      serial_q    <= 1'b1;
      busy_q      <= 1'b0;
      key_ready_q <= 1'b1;
      reject_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      key_q       <= key_d;
      serial_q    <= serial_d;
      busy_q      <= busy_d;
      key_ready_q <= key_ready_d;
      reject_q    <= reject_d;
    end
  end

  assign serial    = serial_q;
  assign busy      = busy_q;
  assign key_ready = key_ready_q;
  assign reject    = reject_q;

endmodule

// File: tb/tb_remote_transmitter.sv
// -----------------------------------------------------------------------------
// tb_remote_transmitter
// Two transmitters: index 0 with default parameters, index 1 with LEAD_LOW=1,
// GAP=5. Each frame is predicted as a list of line bits built from the frame
// format; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_remote_transmitter;

  localparam logic [15:0] CC = 16'hA55A;
  localparam int LL0 = 4, GP0 = 6;
  localparam int LL1 = 1, GP1 = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic       kv [2];
  logic [7:0] ki [2];
  logic       rdy [2];
  logic       ser [2];
  logic       bsy [2];
  logic       rej [2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  remote_transmitter #(.CUSTOM_CODE(CC), .LEAD_LOW(LL0), .GAP(GP0)) u_dut0 (
    .clk(clk), .reset(reset), .key_valid(kv[0]), .key_in(ki[0]),
    .key_ready(rdy[0]), .serial(ser[0]), .busy(bsy[0]), .reject(rej[0])
  );

  remote_transmitter #(.CUSTOM_CODE(CC), .LEAD_LOW(LL1), .GAP(GP1)) u_dut1 (
    .clk(clk), .reset(reset), .key_valid(kv[1]), .key_in(ki[1]),
    .key_ready(rdy[1]), .serial(ser[1]), .busy(bsy[1]), .reject(rej[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit legal_ref(input logic [7:0] k);
    bit a, b, c, d, e;
    if (k > 8'd31) return 1'b0;
    a = k[4]; b = k[3]; c = k[2]; d = k[1]; e = k[0];
    return (!a && !b) || (!b && !c) || (!b && !e) || (a && d) ||
           (!a && !c && !d) || (!a && !d && !e) || (!c && !d && !e) ||
           (c && d && e);
  endfunction

  function automatic int lead_of(input int d);
    return (d == 0) ? LL0 : LL1;
  endfunction

  function automatic int gap_of(input int d);
    return (d == 0) ? GP0 : GP1;
  endfunction

  task automatic check_idle(input int d, input string tag);
    check({tag, ".serial"},    32'(ser[d]), 32'd1);
    check({tag, ".busy"},      32'(bsy[d]), 32'd0);
    check({tag, ".key_ready"}, 32'(rdy[d]), 32'd1);
    check({tag, ".reject"},    32'(rej[d]), 32'd0);
  endtask

  // Called at the falling edge right after the accept edge; checks every
  // line bit through the gap and leaves us at the first IDLE falling edge.
  task automatic check_frame(input int d, input logic [7:0] k);
    bit exp_bits[$];
    int n;
    for (int i = 0; i < lead_of(d); i++) exp_bits.push_back(1'b0);
    exp_bits.push_back(1'b1);
    for (int b = 15; b >= 0; b--) exp_bits.push_back(bit'((int'(CC) >> b) & 1));
    for (int b = 7; b >= 0; b--)  exp_bits.push_back(bit'((int'(k) >> b) & 1));
    for (int b = 7; b >= 0; b--)  exp_bits.push_back(bit'(((int'(k) >> b) & 1) ^ 1));
    for (int i = 0; i < gap_of(d); i++) exp_bits.push_back(1'b1);
    n = exp_bits.size();
    check($sformatf("frame_len%0d", d), 32'(n), 32'(lead_of(d) + 33 + gap_of(d)));
    for (int i = 0; i < n; i++) begin
      check($sformatf("d%0d_k%0h_bit%0d", d, k, i), 32'(ser[d]), 32'(exp_bits[i]));
      check($sformatf("d%0d_k%0h_busy%0d", d, k, i), 32'(bsy[d]), 32'd1);
      check($sformatf("d%0d_k%0h_rdy%0d", d, k, i), 32'(rdy[d]), 32'd0);
      check($sformatf("d%0d_k%0h_rej%0d", d, k, i), 32'(rej[d]), 32'd0);
      @(negedge clk);
    end
    check_idle(d, $sformatf("d%0d_k%0h_end", d, k));
  endtask

  task automatic wait_ready(input int d);
    int t = 0;
    while (!rdy[d] && t < 100) begin
      @(negedge clk);
      t++;
    end
    check($sformatf("wait_ready%0d", d), 32'(rdy[d]), 32'd1);
  endtask

  // Offer one key for one cycle and check the outcome against the model.
  task automatic send(input int d, input logic [7:0] k);
    wait_ready(d);
    kv[d] = 1'b1;
    ki[d] = k;
    @(negedge clk);
    kv[d] = 1'b0;
    ki[d] = $urandom_range(0, 255);
    if (legal_ref(k)) begin
      check_frame(d, k);
    end else begin
      check($sformatf("rej_d%0d_k%0h", d, k),    32'(rej[d]), 32'd1);
      check($sformatf("rejser_d%0d_k%0h", d, k), 32'(ser[d]), 32'd1);
      check($sformatf("rejbsy_d%0d_k%0h", d, k), 32'(bsy[d]), 32'd0);
      check($sformatf("rejrdy_d%0d_k%0h", d, k), 32'(rdy[d]), 32'd1);
      @(negedge clk);
      check_idle(d, $sformatf("rejend_d%0d_k%0h", d, k));
    end
  endtask

  initial begin
    kv[0] = 1'b0; kv[1] = 1'b0;
    ki[0] = 8'h00; ki[1] = 8'h00;
    reset = 1'b0;
    #12;
    check_idle(0, "reset0");
    check_idle(1, "reset1");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_idle(0, "post_reset0");

    // Directed frame and illegal keys.
    send(0, 8'h12);
    send(0, 8'h19);
    send(0, 8'h20);

    // Back-to-back illegal offers give back-to-back reject pulses.
    kv[0] = 1'b1;
    ki[0] = 8'h19;
    @(negedge clk);
    check("b2b_rej0", 32'(rej[0]), 32'd1);
    ki[0] = 8'h20;
    @(negedge clk);
    check("b2b_rej1", 32'(rej[0]), 32'd1);
    check("b2b_bsy", 32'(bsy[0]), 32'd0);
    kv[0] = 1'b0;
    @(negedge clk);
    check_idle(0, "b2b_end");

    // key_valid held across a frame: the key change mid-frame is ignored and
    // the second key is accepted in the first IDLE cycle.
    kv[0] = 1'b1;
    ki[0] = 8'h00;
    @(negedge clk);
    ki[0] = 8'h1F;
    check_frame(0, 8'h00);
    @(negedge clk);
    kv[0] = 1'b0;
    check_frame(0, 8'h1F);

    // Reset during the KEY field aborts the frame immediately.
    wait_ready(0);
    kv[0] = 1'b1;
    ki[0] = 8'h12;
    @(negedge clk);
    kv[0] = 1'b0;
    repeat (LL0 + 17 + 3) @(negedge clk);
    check("pre_abort_busy", 32'(bsy[0]), 32'd1);
    reset = 1'b0;
    #1;
    check_idle(0, "abort");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send(0, 8'h03);

    // Short-preamble, minimum-gap instance.
    send(1, 8'h12);
    send(1, 8'h19);

    // Random keys on both instances; range spans legal, illegal and >31.
    for (int i = 0; i < 24; i++) begin
      send(i % 2, 8'($urandom_range(0, 47)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
